// File: rtl/gpu_pkg.sv
// Shared types and helpers for the GPU memory subsystem.
package gpu_pkg;

  typedef enum logic [2:0] {
    MC_IDLE        = 3'd0,
    MC_READ_WAIT   = 3'd1,
    MC_WRITE_WAIT  = 3'd2,
    MC_READ_RELAY  = 3'd3,
    MC_WRITE_RELAY = 3'd4
  } mc_state_t;

  // Index width that stays legal for a single-entry set.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_arbiter.sv
// Picks one unclaimed requester, searching upward from i_ptr with wrap-around.
// Purely combinational; o_grant is one-hot or zero when o_found is 0.
module mc_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_claim,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_found
);

  logic [N-1:0] w_avail;
  int           w_idx;

  always_comb begin
    w_avail = i_req & ~i_claim;
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_found && w_avail[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Arbitrates consumer read/write requests onto NUM_CHANNELS memory channels and relays responses.
// MEMCTRL_RR_ARB_EN selects round-robin arbitration; otherwise lowest consumer index wins.
module mem_controller
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_EN      = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = idx_width(NUM_CONSUMERS);

  mc_state_t                          r_state [NUM_CHANNELS];
  logic [CW-1:0]                      r_cons  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]           r_claim;
  logic [NUM_CHANNELS-1:0]            r_mem_rd_vld;
  logic [NUM_CHANNELS-1:0]            r_mem_wr_vld;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  r_mem_rd_addr;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  r_mem_wr_addr;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  r_mem_wr_dat;
  logic [NUM_CONSUMERS-1:0]           r_cons_rd_rdy;
  logic [NUM_CONSUMERS-1:0]           r_cons_wr_rdy;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_cons_rd_dat;

  logic [CW-1:0]                      w_ptr;
  logic [NUM_CONSUMERS-1:0]           w_req;
  logic [NUM_CHANNELS-1:0]            w_take_v;
  logic [NUM_CHANNELS-1:0]            w_sel_rd_v;
  logic [NUM_CHANNELS*CW-1:0]         w_sel_v;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  w_rd_addr_v;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  w_wr_addr_v;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  w_wr_dat_v;

  assign w_req = consumer_read_valid | ((WRITE_EN != 0) ? consumer_write_valid : '0);

`ifdef MEMCTRL_RR_ARB_EN
  logic [CW-1:0] r_rr_ptr;
  assign w_ptr = r_rr_ptr;

  // The highest-index channel granting this cycle holds the most recent grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (w_take_v[ch]) begin
          r_rr_ptr <= (w_sel_v[ch*CW +: CW] == CW'(NUM_CONSUMERS - 1)) ? '0
                                                                        : w_sel_v[ch*CW +: CW] + 1'b1;
        end
      end
    end
  end
`else
  assign w_ptr = '0;
`endif

  // Lower channels resolve first; their grants are masked out for the channels above.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] w_excl_in;
    logic [NUM_CONSUMERS-1:0] w_excl_out;
    logic [NUM_CONSUMERS-1:0] w_grant;
    logic                     w_found;
    logic                     w_take;
    logic [CW-1:0]            w_sel;

    if (g == 0) begin : g_first
      assign w_excl_in = r_claim;
    end else begin : g_next
      assign w_excl_in = g_ch[g-1].w_excl_out;
    end

    mc_arbiter #(
      .N  (NUM_CONSUMERS),
      .PW (CW)
    ) u_arb (
      .i_req   (w_req),
      .i_claim (w_excl_in),
      .i_ptr   (w_ptr),
      .o_grant (w_grant),
      .o_found (w_found)
    );

    assign w_take     = (r_state[g] == MC_IDLE) && w_found;
    assign w_excl_out = w_excl_in | (w_take ? w_grant : '0);

    always_comb begin
      w_sel = '0;
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        if (w_grant[c]) w_sel = CW'(c);
      end
    end

    assign w_take_v[g]                         = w_take;
    assign w_sel_v[g*CW +: CW]                 = w_sel;
    assign w_sel_rd_v[g]                       = consumer_read_valid[w_sel];
    assign w_rd_addr_v[g*ADDR_BITS +: ADDR_BITS] = consumer_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
    assign w_wr_addr_v[g*ADDR_BITS +: ADDR_BITS] = consumer_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
    assign w_wr_dat_v[g*DATA_BITS +: DATA_BITS]  = consumer_write_data[w_sel*DATA_BITS +: DATA_BITS];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch] <= MC_IDLE;
        r_cons[ch]  <= '0;
      end
      r_claim       <= '0;
      r_mem_rd_vld  <= '0;
      r_mem_wr_vld  <= '0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_dat  <= '0;
      r_cons_rd_rdy <= '0;
      r_cons_wr_rdy <= '0;
      r_cons_rd_dat <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (r_state[ch])
          MC_IDLE: begin
            if (w_take_v[ch]) begin
              r_cons[ch]                     <= w_sel_v[ch*CW +: CW];
              r_claim[w_sel_v[ch*CW +: CW]]  <= 1'b1;
              if (w_sel_rd_v[ch]) begin
                r_state[ch]                                 <= MC_READ_WAIT;
                r_mem_rd_vld[ch]                            <= 1'b1;
                r_mem_rd_addr[ch*ADDR_BITS +: ADDR_BITS]    <= w_rd_addr_v[ch*ADDR_BITS +: ADDR_BITS];
              end else begin
                r_state[ch]                                 <= MC_WRITE_WAIT;
                r_mem_wr_vld[ch]                            <= 1'b1;
                r_mem_wr_addr[ch*ADDR_BITS +: ADDR_BITS]    <= w_wr_addr_v[ch*ADDR_BITS +: ADDR_BITS];
                r_mem_wr_dat[ch*DATA_BITS +: DATA_BITS]     <= w_wr_dat_v[ch*DATA_BITS +: DATA_BITS];
              end
            end
          end
          MC_READ_WAIT: begin
            if (mem_read_ready[ch]) begin
              r_state[ch]                                        <= MC_READ_RELAY;
              r_mem_rd_vld[ch]                                   <= 1'b0;
              r_mem_rd_addr[ch*ADDR_BITS +: ADDR_BITS]           <= '0;
              r_cons_rd_dat[r_cons[ch]*DATA_BITS +: DATA_BITS]   <= mem_read_data[ch*DATA_BITS +: DATA_BITS];
              r_cons_rd_rdy[r_cons[ch]]                          <= 1'b1;
            end
          end
          MC_WRITE_WAIT: begin
            if (mem_write_ready[ch]) begin
              r_state[ch]                                 <= MC_WRITE_RELAY;
              r_mem_wr_vld[ch]                            <= 1'b0;
              r_mem_wr_addr[ch*ADDR_BITS +: ADDR_BITS]    <= '0;
              r_mem_wr_dat[ch*DATA_BITS +: DATA_BITS]     <= '0;
              r_cons_wr_rdy[r_cons[ch]]                   <= 1'b1;
            end
          end
          // Read data stays latched after ready drops; only the handshake is released.
          MC_READ_RELAY: begin
            if (!consumer_read_valid[r_cons[ch]]) begin
              r_state[ch]               <= MC_IDLE;
              r_cons_rd_rdy[r_cons[ch]] <= 1'b0;
              r_claim[r_cons[ch]]       <= 1'b0;
            end
          end
          MC_WRITE_RELAY: begin
            if (!consumer_write_valid[r_cons[ch]]) begin
              r_state[ch]               <= MC_IDLE;
              r_cons_wr_rdy[r_cons[ch]] <= 1'b0;
              r_claim[r_cons[ch]]       <= 1'b0;
            end
          end
          default: r_state[ch] <= MC_IDLE;
        endcase
      end
    end
  end

  assign consumer_read_ready  = r_cons_rd_rdy;
  assign consumer_read_data   = r_cons_rd_dat;
  assign mem_read_valid       = r_mem_rd_vld;
  assign mem_read_address     = r_mem_rd_addr;
  assign consumer_write_ready = (WRITE_EN != 0) ? r_cons_wr_rdy : '0;
  assign mem_write_valid      = (WRITE_EN != 0) ? r_mem_wr_vld  : '0;
  assign mem_write_address    = (WRITE_EN != 0) ? r_mem_wr_addr : '0;
  assign mem_write_data       = (WRITE_EN != 0) ? r_mem_wr_dat  : '0;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench: single-channel data controller, two-channel controller and a read-only controller.
module tb_mem_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  // u1: one channel, writes enabled
  logic [3:0]  c1_rv, c1_rr, c1_wv, c1_wr;
  logic [31:0] c1_ra, c1_rd, c1_wa, c1_wd;
  logic [0:0]  m1_rv, m1_rrdy, m1_wv, m1_wrdy;
  logic [7:0]  m1_ra, m1_rd, m1_wa, m1_wd;
  // u2: two channels
  logic [3:0]  c2_rv, c2_rr, c2_wv, c2_wr;
  logic [31:0] c2_ra, c2_rd, c2_wa, c2_wd;
  logic [1:0]  m2_rv, m2_wv, m2_wrdy;
  logic [1:0]  m2_rrdy = 2'b00;
  logic [15:0] m2_ra, m2_wa, m2_wd;
  logic [15:0] m2_rd = 16'h0;
  // u3: read-only
  logic [3:0]  c3_rv, c3_rr, c3_wv, c3_wr;
  logic [31:0] c3_ra, c3_rd, c3_wa, c3_wd;
  logic [0:0]  m3_rv, m3_rrdy, m3_wv, m3_wrdy;
  logic [7:0]  m3_ra, m3_rd, m3_wa, m3_wd;

  mem_controller #(.NUM_CHANNELS(1), .WRITE_EN(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
    .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
    .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
    .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
    .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
    .mem_read_ready(m1_rrdy), .mem_read_data(m1_rd),
    .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
    .mem_write_data(m1_wd), .mem_write_ready(m1_wrdy)
  );

  mem_controller #(.NUM_CHANNELS(2), .WRITE_EN(1)) u2 (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(c2_rv), .consumer_read_address(c2_ra),
    .consumer_read_ready(c2_rr), .consumer_read_data(c2_rd),
    .consumer_write_valid(c2_wv), .consumer_write_address(c2_wa),
    .consumer_write_data(c2_wd), .consumer_write_ready(c2_wr),
    .mem_read_valid(m2_rv), .mem_read_address(m2_ra),
    .mem_read_ready(m2_rrdy), .mem_read_data(m2_rd),
    .mem_write_valid(m2_wv), .mem_write_address(m2_wa),
    .mem_write_data(m2_wd), .mem_write_ready(m2_wrdy)
  );

  mem_controller #(.NUM_CHANNELS(1), .WRITE_EN(0)) u3 (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(c3_rv), .consumer_read_address(c3_ra),
    .consumer_read_ready(c3_rr), .consumer_read_data(c3_rd),
    .consumer_write_valid(c3_wv), .consumer_write_address(c3_wa),
    .consumer_write_data(c3_wd), .consumer_write_ready(c3_wr),
    .mem_read_valid(m3_rv), .mem_read_address(m3_ra),
    .mem_read_ready(m3_rrdy), .mem_read_data(m3_rd),
    .mem_write_valid(m3_wv), .mem_write_address(m3_wa),
    .mem_write_data(m3_wd), .mem_write_ready(m3_wrdy)
  );

  // Memory model for u2: answers every read one cycle later with data = address + 0x80.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      m2_rrdy[ch]       = m2_rv[ch];
      m2_rd[ch*8 +: 8]  = m2_ra[ch*8 +: 8] + 8'h80;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  typedef struct {
    bit         wr;
    int         cons;
    logic [7:0] addr;
    logic [7:0] wdat;
    logic [7:0] rdat;
    int         lat;
    logic [3:0] exp_rdy;
    logic [7:0] exp_maddr;
    logic [7:0] exp_mdat;
    logic [7:0] exp_cdat;
  } vec_t;

  vec_t vecs[4];
  int   c, f, s;

  initial begin
    vecs[0] = '{1'b0, 0, 8'h12, 8'h00, 8'hAB, 3, 4'b0001, 8'h12, 8'h00, 8'hAB};
    vecs[1] = '{1'b1, 2, 8'h40, 8'h5C, 8'h00, 1, 4'b0100, 8'h40, 8'h5C, 8'h00};
    vecs[2] = '{1'b0, 3, 8'h7F, 8'h00, 8'h3C, 0, 4'b1000, 8'h7F, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 1, 8'hFF, 8'h01, 8'h00, 2, 4'b0010, 8'hFF, 8'h01, 8'h00};

    reset_n = 1'b0;
    c1_rv = '0; c1_ra = '0; c1_wv = '0; c1_wa = '0; c1_wd = '0;
    m1_rrdy = '0; m1_rd = '0; m1_wrdy = '0;
    c2_rv = '0; c2_ra = '0; c2_wv = '0; c2_wa = '0; c2_wd = '0; m2_wrdy = '0;
    c3_rv = '0; c3_ra = '0; c3_wv = '0; c3_wa = '0; c3_wd = '0;
    m3_rrdy = '0; m3_rd = '0; m3_wrdy = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;

    chk("rst_m1_rv", m1_rv, 0);
    chk("rst_c1_rr", c1_rr, 0);
    chk("rst_c1_rd", c1_rd, 0);
    chk("rst_m2_rv", m2_rv, 0);
    chk("rst_m2_ra", m2_ra, 0);

    // Stray ready pulses while idle
    m1_rrdy = 1'b1; m1_wrdy = 1'b1;
    tick();
    m1_rrdy = 1'b0; m1_wrdy = 1'b0;
    chk("idle_pulse_rr", c1_rr, 0);
    chk("idle_pulse_wr", c1_wr, 0);
    chk("idle_pulse_mrv", m1_rv, 0);

    for (int i = 0; i < 4; i++) begin
      c = vecs[i].cons;
      if (vecs[i].wr) begin
        c1_wv[c] = 1'b1; c1_wa[c*8 +: 8] = vecs[i].addr; c1_wd[c*8 +: 8] = vecs[i].wdat;
      end else begin
        c1_rv[c] = 1'b1; c1_ra[c*8 +: 8] = vecs[i].addr;
      end
      tick();
      if (vecs[i].wr) begin
        chk("wr_issue_vld", m1_wv, 1);
        chk("wr_issue_addr", m1_wa, vecs[i].exp_maddr);
        chk("wr_issue_data", m1_wd, vecs[i].exp_mdat);
      end else begin
        chk("rd_issue_vld", m1_rv, 1);
        chk("rd_issue_addr", m1_ra, vecs[i].exp_maddr);
      end
      chk("no_early_ready", c1_rr | c1_wr, 0);
      repeat (vecs[i].lat) tick();
      if (vecs[i].wr) m1_wrdy = 1'b1; else m1_rrdy = 1'b1;
      m1_rd = vecs[i].rdat;
      tick();
      m1_rrdy = 1'b0; m1_wrdy = 1'b0;
      if (vecs[i].wr) begin
        chk("wr_ready", c1_wr, vecs[i].exp_rdy);
        chk("wr_vld_drop", m1_wv, 0);
        chk("wr_rd_quiet", c1_rr, 0);
      end else begin
        chk("rd_ready", c1_rr, vecs[i].exp_rdy);
        chk("rd_data", c1_rd[c*8 +: 8], vecs[i].exp_cdat);
        chk("rd_vld_drop", m1_rv, 0);
        chk("rd_wr_quiet", c1_wr, 0);
      end
      tick();
      chk("ready_hold", vecs[i].wr ? c1_wr : c1_rr, vecs[i].exp_rdy);
      c1_rv = '0; c1_wv = '0;
      tick();
      chk("ready_drop", c1_rr | c1_wr, 0);
      if (!vecs[i].wr) chk("rd_data_hold", c1_rd[c*8 +: 8], vecs[i].exp_cdat);
    end

    // Contention: consumers 1 and 3; last grant was consumer 1
`ifdef MEMCTRL_RR_ARB_EN
    f = 3; s = 1;
`else
    f = 1; s = 3;
`endif
    c1_ra = 32'h23002100;
    c1_rv = 4'b1010;
    tick();
    chk("cont_first_addr", m1_ra, 32'h20 + f);
    m1_rrdy = 1'b1; m1_rd = 8'(f * 8'h11);
    tick();
    m1_rrdy = 1'b0;
    chk("cont_first_rdy", c1_rr, 1 << f);
    c1_rv[f] = 1'b0;
    tick();
    chk("cont_first_drop", c1_rr, 0);
    tick();
    chk("cont_second_vld", m1_rv, 1);
    chk("cont_second_addr", m1_ra, 32'h20 + s);
    m1_rrdy = 1'b1; m1_rd = 8'(s * 8'h11);
    tick();
    m1_rrdy = 1'b0;
    chk("cont_second_rdy", c1_rr, 1 << s);
    chk("cont_second_data", c1_rd[s*8 +: 8], s * 8'h11);
    c1_rv = '0;
    tick();
    chk("cont_second_drop", c1_rr, 0);

    // Read and write together on consumer 0
    c1_ra[7:0] = 8'h05; c1_wa[7:0] = 8'h06; c1_wd[7:0] = 8'h77;
    c1_rv = 4'b0001; c1_wv = 4'b0001;
    tick();
    chk("conf_rd_first", m1_rv, 1);
    chk("conf_wr_wait", m1_wv, 0);
    chk("conf_rd_addr", m1_ra, 8'h05);
    c1_ra[7:0] = 8'h99;
    tick();
    chk("conf_addr_stable", m1_ra, 8'h05);
    m1_rrdy = 1'b1; m1_rd = 8'h55;
    tick();
    m1_rrdy = 1'b0;
    chk("conf_rd_rdy", c1_rr, 4'b0001);
    chk("conf_rd_data", c1_rd[7:0], 8'h55);
    chk("conf_wr_not_rdy", c1_wr, 0);
    c1_rv = '0;
    tick();
    chk("conf_rd_drop", c1_rr, 0);
    tick();
    chk("conf_wr_vld", m1_wv, 1);
    chk("conf_wr_addr", m1_wa, 8'h06);
    chk("conf_wr_data", m1_wd, 8'h77);
    m1_wrdy = 1'b1;
    tick();
    m1_wrdy = 1'b0;
    chk("conf_wr_rdy", c1_wr, 4'b0001);
    c1_wv = '0;
    tick();
    chk("conf_wr_drop", c1_wr, 0);

    // Reset while waiting for memory
    c1_ra[7:0] = 8'h33;
    c1_rv = 4'b0001;
    tick();
    chk("rstw_issue", m1_rv, 1);
    reset_n = 1'b0;
    tick();
    chk("rstw_mrv", m1_rv, 0);
    chk("rstw_mra", m1_ra, 0);
    chk("rstw_rd", c1_rd, 0);
    chk("rstw_rr", c1_rr, 0);
    reset_n = 1'b1;
    c1_rv = '0;
    m1_rrdy = 1'b1; m1_rd = 8'hEE;
    tick();
    m1_rrdy = 1'b0;
    chk("rstw_late_rdy", c1_rr, 0);
    chk("rstw_late_data", c1_rd, 0);

    // Two channels, four reads
    c2_ra = 32'h03020100;
    c2_rv = 4'b1111;
    tick();
    chk("dual_vld_a", m2_rv, 2'b11);
    chk("dual_addr_a", m2_ra, 16'h0100);
    tick();
    chk("dual_rdy_a", c2_rr, 4'b0011);
    chk("dual_data_a", c2_rd[15:0], 16'h8180);
    chk("dual_vld_drop", m2_rv, 0);
    c2_rv = 4'b1100;
    tick();
    chk("dual_rel_a", c2_rr, 0);
    tick();
    chk("dual_vld_b", m2_rv, 2'b11);
    chk("dual_addr_b", m2_ra, 16'h0302);
    tick();
    chk("dual_rdy_b", c2_rr, 4'b1100);
    chk("dual_data_all", c2_rd, 32'h83828180);
    c2_rv = '0;
    tick();
    chk("dual_rel_b", c2_rr, 0);

    // Read-only instance ignores writes
    c3_wa[7:0] = 8'h10; c3_wd[7:0] = 8'hA5;
    c3_wv = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ro_no_wr_vld", m3_wv, 0);
      chk("ro_no_wr_rdy", c3_wr, 0);
    end
    c3_wv = '0;
    c3_ra[15:8] = 8'h44;
    c3_rv = 4'b0010;
    tick();
    chk("ro_rd_vld", m3_rv, 1);
    chk("ro_rd_addr", m3_ra, 8'h44);
    chk("ro_wr_quiet", m3_wv, 0);
    m3_rrdy = 1'b1; m3_rd = 8'h9C;
    tick();
    m3_rrdy = 1'b0;
    chk("ro_rd_rdy", c3_rr, 4'b0010);
    chk("ro_rd_data", c3_rd[15:8], 8'h9C);
    chk("ro_wr_rdy", c3_wr, 0);
    c3_rv = '0;
    tick();
    chk("ro_rd_drop", c3_rr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
